// File: rtl/memio_bram_responder_if.sv
// MemIO port bundle between Top (master) and the block-RAM responder (slave).
// Carries the command channel (valid/ready/addr/tag/rw), the write-data
// channel (valid/ready/data) and the read-response channel (valid/ready/
// data/tag). Clock and reset are kept outside the bundle.
interface memio_bram_responder_if #(
  parameter int ADDR_BITS = 26,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128
);
  logic                 io_mem_req_cmd_valid;
  logic                 io_mem_req_cmd_ready;
  logic [ADDR_BITS-1:0] io_mem_req_cmd_bits_addr;
  logic [TAG_BITS-1:0]  io_mem_req_cmd_bits_tag;
  logic                 io_mem_req_cmd_bits_rw;
  logic                 io_mem_req_data_valid;
  logic                 io_mem_req_data_ready;
  logic [DATA_BITS-1:0] io_mem_req_data_bits_data;
  logic                 io_mem_resp_valid;
  logic                 io_mem_resp_ready;
  logic [DATA_BITS-1:0] io_mem_resp_bits_data;
  logic [TAG_BITS-1:0]  io_mem_resp_bits_tag;

  modport master (
    output io_mem_req_cmd_valid, io_mem_req_cmd_bits_addr, io_mem_req_cmd_bits_tag,
           io_mem_req_cmd_bits_rw, io_mem_req_data_valid, io_mem_req_data_bits_data,
           io_mem_resp_ready,
    input  io_mem_req_cmd_ready, io_mem_req_data_ready, io_mem_resp_valid,
           io_mem_resp_bits_data, io_mem_resp_bits_tag
  );

  modport slave (
    input  io_mem_req_cmd_valid, io_mem_req_cmd_bits_addr, io_mem_req_cmd_bits_tag,
           io_mem_req_cmd_bits_rw, io_mem_req_data_valid, io_mem_req_data_bits_data,
           io_mem_resp_ready,
    output io_mem_req_cmd_ready, io_mem_req_data_ready, io_mem_resp_valid,
           io_mem_resp_bits_data, io_mem_resp_bits_tag
  );
endinterface

// File: rtl/memio_bram_responder.sv
// Block-RAM responder for the Rocket MemIO port. Each command moves one line
// of LINE_BEATS beats: writes consume data beats into RAM, reads stream the
// line back on the response channel tagged with the command tag.
// Ports:
//   clk   - host clock, rising edge
//   reset - synchronous, active-high
//   mem   - MemIO bundle (slave side): req_cmd, req_data, resp
module memio_bram_responder #(
  parameter int ADDR_BITS  = 26,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BITS  = 128,
  parameter int LINE_BEATS = 4,
  parameter int INDEX_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  memio_bram_responder_if.slave mem
);
  localparam int BEAT_BITS  = $clog2(LINE_BEATS);
  localparam int WADDR_BITS = INDEX_BITS + BEAT_BITS;
  localparam int DEPTH      = 1 << WADDR_BITS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state, state_nxt;

  logic [INDEX_BITS-1:0] index_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [BEAT_BITS-1:0]  beat_q;       // write beat in WRITE, issue beat in READ
  logic [BEAT_BITS-1:0]  resp_beat_q;  // beats handed out on resp
  logic                  issue_done_q;
  logic                  resp_valid_q;
  logic [DATA_BITS-1:0]  rd_q;
  logic [DATA_BITS-1:0]  ram [0:DEPTH-1];

  logic cmd_ready_c, data_ready_c, ram_re;
  logic cmd_fire, data_fire, resp_fire, advance;
  logic [WADDR_BITS-1:0] ram_addr;

  // Line addresses alias modulo 2^INDEX_BITS; the upper bits are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem.io_mem_req_cmd_bits_addr[ADDR_BITS-1:INDEX_BITS];

  assign cmd_fire  = mem.io_mem_req_cmd_valid && cmd_ready_c;
  assign data_fire = mem.io_mem_req_data_valid && data_ready_c;
  assign resp_fire = resp_valid_q && mem.io_mem_resp_ready;
  // Output stage is free or being drained this cycle.
  assign advance   = !resp_valid_q || mem.io_mem_resp_ready;
  assign ram_addr  = {index_q, beat_q};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cmd_ready_c  = 1'b0;
    data_ready_c = 1'b0;
    ram_re       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (mem.io_mem_req_cmd_valid)
          state_nxt = mem.io_mem_req_cmd_bits_rw ? WRITE : READ;
      end
      WRITE: begin
        data_ready_c = 1'b1;
        if (mem.io_mem_req_data_valid && beat_q == LAST_BEAT) state_nxt = IDLE;
      end
      READ: begin
        // A stalled output stage blocks the read so rd_q holds its beat.
        ram_re = advance && !issue_done_q;
        if (resp_fire && resp_beat_q == LAST_BEAT) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      cmd_ready_c  = 1'b0;
      data_ready_c = 1'b0;
      ram_re       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_q      <= '0;
      tag_q        <= '0;
      beat_q       <= '0;
      resp_beat_q  <= '0;
      issue_done_q <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      if (cmd_fire) begin
        index_q      <= mem.io_mem_req_cmd_bits_addr[INDEX_BITS-1:0];
        tag_q        <= mem.io_mem_req_cmd_bits_tag;
        beat_q       <= '0;
        resp_beat_q  <= '0;
        issue_done_q <= 1'b0;
      end
      if (data_fire) beat_q <= beat_q + 1'b1;
      if (ram_re) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == LAST_BEAT) issue_done_q <= 1'b1;
      end
      if (advance)   resp_valid_q <= ram_re;
      if (resp_fire) resp_beat_q  <= resp_beat_q + 1'b1;
    end
  end

  // Single-port RAM: one shared address, write and read never coincide.
  always_ff @(posedge clk) begin
    if (data_fire) ram[ram_addr] <= mem.io_mem_req_data_bits_data;
    if (ram_re)    rd_q <= ram[ram_addr];
  end

  assign mem.io_mem_req_cmd_ready  = cmd_ready_c;
  assign mem.io_mem_req_data_ready = data_ready_c;
  assign mem.io_mem_resp_valid     = resp_valid_q;
  assign mem.io_mem_resp_bits_data = rd_q;
  assign mem.io_mem_resp_bits_tag  = tag_q;
endmodule

// File: tb/tb_memio_bram_responder.sv
// Directed bench for memio_bram_responder: reset, write/read, stall,
// aliasing, gapped writes, reset mid-read, back-to-back commands.
module tb_memio_bram_responder;
  localparam int AB = 26;
  localparam int TB = 5;
  localparam int DB = 128;

  typedef logic [DB-1:0] line_t [4];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memio_bram_responder_if #(.ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB)) mif ();

  memio_bram_responder #(
    .ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB), .LINE_BEATS(4), .INDEX_BITS(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem(mif)
  );

  int total = 0;
  int bad   = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mif.io_mem_req_cmd_valid      = 1'b0;
    mif.io_mem_req_cmd_bits_addr  = '0;
    mif.io_mem_req_cmd_bits_tag   = '0;
    mif.io_mem_req_cmd_bits_rw    = 1'b0;
    mif.io_mem_req_data_valid     = 1'b0;
    mif.io_mem_req_data_bits_data = '0;
    mif.io_mem_resp_ready         = 1'b0;
  endtask

  // Returns in the cycle after the accepting edge.
  task automatic send_cmd(input logic [AB-1:0] a, input logic [TB-1:0] t, input logic rw);
    int n;
    n = 0;
    mif.io_mem_req_cmd_valid     = 1'b1;
    mif.io_mem_req_cmd_bits_addr = a;
    mif.io_mem_req_cmd_bits_tag  = t;
    mif.io_mem_req_cmd_bits_rw   = rw;
    while (!mif.io_mem_req_cmd_ready && n < 50) begin cyc(); n++; end
    if (!mif.io_mem_req_cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept_timeout got=ready_low exp=ready_high");
    end
    cyc();
    mif.io_mem_req_cmd_valid = 1'b0;
  endtask

  // Drives 4 beats with 'gap' idle cycles before each; counts cycles waited on
  // data_ready and cycles where cmd_ready was seen high.
  task automatic send_beats(input line_t d, input int gap, output int stall, output int busy);
    int n;
    stall = 0; busy = 0;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        mif.io_mem_req_data_valid = 1'b0;
        if (mif.io_mem_req_cmd_ready) busy++;
        cyc();
      end
      mif.io_mem_req_data_valid     = 1'b1;
      mif.io_mem_req_data_bits_data = d[i];
      n = 0;
      while (!mif.io_mem_req_data_ready && n < 50) begin
        if (mif.io_mem_req_cmd_ready) busy++;
        cyc(); n++; stall++;
      end
      if (!mif.io_mem_req_data_ready) begin
        total++; bad++;
        $display("FAIL data_accept_timeout beat=%0d", i);
      end
      if (mif.io_mem_req_cmd_ready) busy++;
      cyc();
    end
    mif.io_mem_req_data_valid = 1'b0;
  endtask

  // Collects 4 beats with resp_ready held high; when[i] is the cycle index
  // (0 = cycle after accept) in which beat i was handed over.
  task automatic recv_beats(output line_t d, output logic [TB-1:0] tg [4],
                            output int when [4], output int busy);
    int k;
    k = 0; busy = 0;
    for (int i = 0; i < 4; i++) begin d[i] = '0; tg[i] = '0; when[i] = -1; end
    mif.io_mem_resp_ready = 1'b1;
    for (int c = 0; c < 60 && k < 4; c++) begin
      if (mif.io_mem_req_cmd_ready) busy++;
      if (mif.io_mem_resp_valid) begin
        d[k] = mif.io_mem_resp_bits_data; tg[k] = mif.io_mem_resp_bits_tag; when[k] = c; k++;
      end
      cyc();
    end
    mif.io_mem_resp_ready = 1'b0;
    if (k != 4) begin
      total++; bad++;
      $display("FAIL resp_timeout got=%0d beats exp=4", k);
    end
  endtask

  line_t line_a, line_d, line_g;

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cyc(); cyc();
    total++; if (mif.io_mem_req_cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", mif.io_mem_req_cmd_ready); end
    total++; if (mif.io_mem_req_data_ready !== 1'b0) begin bad++; $display("FAIL rst_data_ready got=%b exp=0", mif.io_mem_req_data_ready); end
    total++; if (mif.io_mem_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", mif.io_mem_resp_valid); end
    total++; if (mif.io_mem_resp_bits_tag !== 5'd0) begin bad++; $display("FAIL rst_resp_tag got=%h exp=0", mif.io_mem_resp_bits_tag); end
    reset = 1'b0;
    cyc();
    total++; if (mif.io_mem_req_cmd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_cmd_ready got=%b exp=1", mif.io_mem_req_cmd_ready); end
    total++; if (mif.io_mem_req_data_ready !== 1'b0) begin bad++; $display("FAIL post_rst_data_ready got=%b exp=0", mif.io_mem_req_data_ready); end
  endtask

  task automatic test_write_read();
    int stall, busy;
    line_t got;
    logic [TB-1:0] tg [4];
    int when [4];
    line_a[0] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A0;
    line_a[1] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A1;
    line_a[2] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A2;
    line_a[3] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A3;
    send_cmd(26'h5, 5'd3, 1'b1);
    send_beats(line_a, 0, stall, busy);
    total++; if (stall !== 0) begin bad++; $display("FAIL wr_data_ready_run got=%0d stalls exp=0", stall); end
    total++; if (busy !== 0) begin bad++; $display("FAIL wr_busy_cmd_ready got=%0d exp=0", busy); end
    total++; if (mif.io_mem_req_cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_done_cmd_ready got=%b exp=1", mif.io_mem_req_cmd_ready); end
    send_cmd(26'h5, 5'd7, 1'b0);
    recv_beats(got, tg, when, busy);
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== line_a[i]) begin bad++; $display("FAIL rd_data[%0d] got=%h exp=%h", i, got[i], line_a[i]); end
      total++; if (tg[i] !== 5'd7) begin bad++; $display("FAIL rd_tag[%0d] got=%h exp=7", i, tg[i]); end
      total++; if (when[i] !== i + 1) begin bad++; $display("FAIL rd_timing[%0d] got=%0d exp=%0d", i, when[i], i + 1); end
    end
    total++; if (busy !== 0) begin bad++; $display("FAIL rd_busy_cmd_ready got=%0d exp=0", busy); end
    total++; if (mif.io_mem_req_cmd_ready !== 1'b1) begin bad++; $display("FAIL rd_done_cmd_ready got=%b exp=1", mif.io_mem_req_cmd_ready); end
  endtask

  task automatic test_stall();
    int pat [7];
    int k, j;
    logic stalled;
    logic [DB-1:0] pd;
    logic [TB-1:0] pt;
    line_t got;
    logic [TB-1:0] tg [4];
    pat = '{1, 0, 0, 1, 0, 1, 1};
    k = 0; j = 0; stalled = 1'b0; pd = '0; pt = '0;
    for (int i = 0; i < 4; i++) begin got[i] = '0; tg[i] = '0; end
    send_cmd(26'h5, 5'd17, 1'b0);
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (stalled) begin
        total++;
        if (mif.io_mem_resp_valid !== 1'b1 || mif.io_mem_resp_bits_data !== pd || mif.io_mem_resp_bits_tag !== pt) begin
          bad++;
          $display("FAIL stall_hold got=v%b %h t%h exp=v1 %h t%h", mif.io_mem_resp_valid,
                   mif.io_mem_resp_bits_data, mif.io_mem_resp_bits_tag, pd, pt);
        end
      end
      if (mif.io_mem_resp_valid) begin
        mif.io_mem_resp_ready = (j < 7) ? pat[j][0] : 1'b1;
        j++;
      end else begin
        mif.io_mem_resp_ready = 1'b0;
      end
      stalled = mif.io_mem_resp_valid && !mif.io_mem_resp_ready;
      pd = mif.io_mem_resp_bits_data;
      pt = mif.io_mem_resp_bits_tag;
      if (mif.io_mem_resp_valid && mif.io_mem_resp_ready) begin
        got[k] = mif.io_mem_resp_bits_data; tg[k] = mif.io_mem_resp_bits_tag; k++;
      end
      cyc();
    end
    mif.io_mem_resp_ready = 1'b0;
    total++; if (k !== 4) begin bad++; $display("FAIL stall_beats got=%0d exp=4", k); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== line_a[i] || tg[i] !== 5'd17) begin
        bad++; $display("FAIL stall_beat[%0d] got=%h t%h exp=%h t11", i, got[i], tg[i], line_a[i]);
      end
    end
    total++; if (mif.io_mem_resp_valid !== 1'b0) begin bad++; $display("FAIL stall_extra_beat got=%b exp=0", mif.io_mem_resp_valid); end
    total++; if (mif.io_mem_req_cmd_ready !== 1'b1) begin bad++; $display("FAIL stall_done_cmd_ready got=%b exp=1", mif.io_mem_req_cmd_ready); end
  endtask

  task automatic test_alias();
    int stall, busy;
    line_t got;
    logic [TB-1:0] tg [4];
    int when [4];
    for (int i = 0; i < 4; i++) line_d[i] = {96'hD00D_FACE_0000_0000_0000_0000, 32'(i)};
    send_cmd(26'h005, 5'd1, 1'b1);
    send_beats(line_d, 0, stall, busy);
    send_cmd(26'h405, 5'd4, 1'b0);
    recv_beats(got, tg, when, busy);
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== line_d[i]) begin bad++; $display("FAIL alias_data[%0d] got=%h exp=%h", i, got[i], line_d[i]); end
    end
    total++; if (tg[3] !== 5'd4) begin bad++; $display("FAIL alias_tag got=%h exp=4", tg[3]); end
  endtask

  task automatic test_write_gaps();
    int stall, busy;
    line_t got;
    logic [TB-1:0] tg [4];
    int when [4];
    for (int i = 0; i < 4; i++) line_g[i] = {64'h6A90_0000_0000_0009, 64'(i * 3 + 1)};
    // Data offered while idle must not be taken.
    mif.io_mem_req_data_valid     = 1'b1;
    mif.io_mem_req_data_bits_data = {DB{1'b1}};
    total++; if (mif.io_mem_req_data_ready !== 1'b0) begin bad++; $display("FAIL idle_data_ready got=%b exp=0", mif.io_mem_req_data_ready); end
    cyc();
    mif.io_mem_req_data_valid = 1'b0;
    send_cmd(26'h009, 5'd2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (mif.io_mem_req_data_ready !== 1'b1 || mif.io_mem_req_cmd_ready !== 1'b0) begin
        bad++; $display("FAIL gap_wait[%0d] got=dr%b cr%b exp=dr1 cr0", c, mif.io_mem_req_data_ready, mif.io_mem_req_cmd_ready);
      end
      cyc();
    end
    send_beats(line_g, 2, stall, busy);
    total++; if (stall !== 0) begin bad++; $display("FAIL gap_stall got=%0d exp=0", stall); end
    total++; if (busy !== 0) begin bad++; $display("FAIL gap_busy_cmd_ready got=%0d exp=0", busy); end
    total++; if (mif.io_mem_req_cmd_ready !== 1'b1) begin bad++; $display("FAIL gap_done_cmd_ready got=%b exp=1", mif.io_mem_req_cmd_ready); end
    send_cmd(26'h009, 5'd9, 1'b0);
    recv_beats(got, tg, when, busy);
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== line_g[i]) begin bad++; $display("FAIL gap_data[%0d] got=%h exp=%h", i, got[i], line_g[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    int k, busy;
    line_t got;
    logic [TB-1:0] tg [4];
    int when [4];
    logic [DB-1:0] first [2];
    k = 0; first[0] = '0; first[1] = '0;
    send_cmd(26'h009, 5'd6, 1'b0);
    mif.io_mem_resp_ready = 1'b1;
    for (int c = 0; c < 20 && k < 2; c++) begin
      if (mif.io_mem_resp_valid) begin first[k] = mif.io_mem_resp_bits_data; k++; end
      cyc();
    end
    total++; if (first[0] !== line_g[0] || first[1] !== line_g[1]) begin
      bad++; $display("FAIL rst_rd_partial got=%h %h exp=%h %h", first[0], first[1], line_g[0], line_g[1]);
    end
    reset = 1'b1;
    cyc();
    total++; if (mif.io_mem_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", mif.io_mem_resp_valid); end
    reset = 1'b0;
    mif.io_mem_resp_ready = 1'b0;
    cyc();
    total++; if (mif.io_mem_req_cmd_ready !== 1'b1 || mif.io_mem_resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_rd_idle got=cr%b v%b exp=cr1 v0", mif.io_mem_req_cmd_ready, mif.io_mem_resp_valid);
    end
    send_cmd(26'h009, 5'd8, 1'b0);
    recv_beats(got, tg, when, busy);
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== line_g[i] || tg[i] !== 5'd8 || when[i] !== i + 1) begin
        bad++; $display("FAIL rst_reread[%0d] got=%h t%h @%0d exp=%h t08 @%0d", i, got[i], tg[i], when[i], line_g[i], i + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int stall, busy;
    line_t l1, l2, got;
    logic [TB-1:0] tg [4];
    int when [4];
    logic [TB-1:0] t [4];
    for (int i = 0; i < 4; i++) begin
      t[i]  = TB'($urandom_range(0, 31));
      l1[i] = {64'hB1B1_0000_0000_0001, 64'(i)};
      l2[i] = {64'hB2B2_0000_0000_0002, 64'(i + 16)};
    end
    for (int p = 0; p < 2; p++) begin
      send_cmd(AB'(p + 1), t[2 * p], 1'b1);
      send_beats(p == 0 ? l1 : l2, 0, stall, busy);
      total++; if (busy !== 0) begin bad++; $display("FAIL b2b_wr_busy[%0d] got=%0d exp=0", p, busy); end
      send_cmd(AB'(p + 1), t[2 * p + 1], 1'b0);
      recv_beats(got, tg, when, busy);
      total++; if (busy !== 0) begin bad++; $display("FAIL b2b_rd_busy[%0d] got=%0d exp=0", p, busy); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== (p == 0 ? l1[i] : l2[i]) || tg[i] !== t[2 * p + 1]) begin
          bad++; $display("FAIL b2b_rd[%0d][%0d] got=%h t%h exp=%h t%h", p, i, got[i], tg[i],
                          p == 0 ? l1[i] : l2[i], t[2 * p + 1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall();
    test_alias();
    test_write_gaps();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
